// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer
//   Streams one frame of UNITS_NUMBER pixels from a pattern ROM to a
//   WS2811 bit transmitter. Each new frame reads the pattern starting one
//   pixel further along (rotating shift), so repeated frames scroll it.
//   After the last pixel, the line is held idle for the latch gap.
//   A trigger that arrives during a frame is kept as one pending request.
//   Any further trigger is discarded and reported on triggerDroppedOUT.
//
// Ports
//   clkIN             : clock, rising edge
//   nResetIN          : asynchronous active-low reset
//   frameTriggerIN    : frame request, sampled every cycle
//   romAddressOUT     : registered pattern ROM read address
//   romDataIN         : ROM read data (GRB), valid one cycle after address
//   brightnessIN      : per-channel scale 0..255 (only with WS2811_BRIGHTNESS_EN)
//   txStartOUT        : one-cycle start pulse to the transmitter
//   txDataOUT         : pixel for the transmitter, stable until it goes busy
//   txBusyIN          : transmitter busy
//   busyOUT           : sequencer not idle
//   frameDoneOUT      : one-cycle pulse when the latch gap completes
//   triggerDroppedOUT : one-cycle pulse when a trigger is discarded
//
// Build option
//   WS2811_BRIGHTNESS_EN : adds brightnessIN. Each channel is scaled by
//                          (brightness+1)/256 as it loads into txDataOUT.
//
// If txBusyIN never falls, the frame stalls in WAIT_TX. There is no timeout.

module ws2811_frame_sequencer #(
  parameter int unsigned UNITS_NUMBER          = 100,
  parameter int unsigned PATTERN_PIXELS_NUMBER = 128,
  parameter int unsigned CLOCK_SPEED           = 50_000_000,
  parameter int unsigned LATCH_US              = 300
) (
  input  logic                                     clkIN,
  input  logic                                     nResetIN,
  input  logic                                     frameTriggerIN,
  output logic [$clog2(PATTERN_PIXELS_NUMBER)-1:0] romAddressOUT,
  input  logic [23:0]                              romDataIN,
`ifdef WS2811_BRIGHTNESS_EN
  input  logic [7:0]                               brightnessIN,
`endif
  output logic                                     txStartOUT,
  output logic [23:0]                              txDataOUT,
  input  logic                                     txBusyIN,
  output logic                                     busyOUT,
  output logic                                     frameDoneOUT,
  output logic                                     triggerDroppedOUT
);

  localparam int unsigned AW           = $clog2(PATTERN_PIXELS_NUMBER);
  localparam int unsigned PW           = $clog2(UNITS_NUMBER + 1);
  localparam int unsigned LATCH_RAW    = CLOCK_SPEED / 1_000_000 * LATCH_US;
  localparam int unsigned LATCH_CYCLES = (LATCH_RAW == 0) ? 1 : LATCH_RAW;
  localparam int unsigned LW           = $clog2(LATCH_CYCLES + 1);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(PATTERN_PIXELS_NUMBER - 1);
  localparam logic [PW-1:0] LAST_PIXEL = PW'(UNITS_NUMBER - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    LOAD,
    WAIT_ACK,
    WAIT_TX,
    LATCH
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [AW-1:0] shift;
  logic [AW-1:0] shiftNext;
  logic [AW-1:0] addrInc;
  logic [PW-1:0] pixelIndex;
  logic [LW-1:0] latchCount;
  logic [1:0]    prefetchCount;
  logic [23:0]   holdData;
  logic [23:0]   loadSource;
  logic [23:0]   loadData;
  logic          pending;
  logic          pendingNext;
  logic          triggerDrop;
  logic          latchEnd;

`ifdef WS2811_BRIGHTNESS_EN
  function automatic logic [7:0] scaleChannel(input logic [7:0] ch, input logic [7:0] level);
    logic [15:0] product;
    product = 16'(ch) * 16'({1'b0, level} + 9'd1);
    return product[15:8];
  endfunction
`endif

  // The address is tracked incrementally as (pixelIndex + shift) mod depth.
  // Each step is a compare-and-wrap, so non-power-of-two depths wrap
  // correctly without a divider.
  assign addrInc   = (romAddressOUT == LAST_ADDR) ? '0 : romAddressOUT + AW'(1);
  assign shiftNext = (shift == LAST_ADDR) ? '0 : shift + AW'(1);
  assign latchEnd  = (state == LATCH) && (latchCount == LATCH_LAST);
  assign busyOUT   = (state != IDLE);

  always_comb begin
    stateNext   = state;
    pendingNext = pending;
    triggerDrop = 1'b0;
    loadSource  = (state == WAIT_DATA) ? romDataIN : holdData;
`ifdef WS2811_BRIGHTNESS_EN
    loadData    = {scaleChannel(loadSource[23:16], brightnessIN),
                   scaleChannel(loadSource[15:8],  brightnessIN),
                   scaleChannel(loadSource[7:0],   brightnessIN)};
`else
    loadData    = loadSource;
`endif

    unique case (state)
      IDLE:      if (frameTriggerIN || pending) stateNext = FETCH;
      FETCH:     stateNext = WAIT_DATA;
      WAIT_DATA: stateNext = LOAD;
      LOAD:      stateNext = WAIT_ACK;
      WAIT_ACK:  if (txBusyIN) stateNext = WAIT_TX;
      WAIT_TX: begin
        // Leaving for the next pixel also waits until the prefetched word
        // has been captured into holdData.
        if (!txBusyIN) begin
          if (pixelIndex == LAST_PIXEL)     stateNext = LATCH;
          else if (prefetchCount == 2'd2)   stateNext = LOAD;
        end
      end
      LATCH:     if (latchEnd) stateNext = (pending || frameTriggerIN) ? FETCH : IDLE;
      default:   stateNext = IDLE;
    endcase

    // A trigger on the final latch cycle starts the next frame directly.
    // If a request was already pending, the pending request is consumed and
    // the new trigger becomes pending. Neither is dropped.
    if (state == IDLE) begin
      if (frameTriggerIN || pending) pendingNext = 1'b0;
    end else if (latchEnd) begin
      pendingNext = pending && frameTriggerIN;
    end else if (frameTriggerIN) begin
      if (pending) triggerDrop = 1'b1;
      else         pendingNext = 1'b1;
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state             <= IDLE;
      romAddressOUT     <= '0;
      txStartOUT        <= 1'b0;
      txDataOUT         <= '0;
      frameDoneOUT      <= 1'b0;
      triggerDroppedOUT <= 1'b0;
      shift             <= '0;
      pixelIndex        <= '0;
      pending           <= 1'b0;
      latchCount        <= '0;
      prefetchCount     <= '0;
      holdData          <= '0;
    end else begin
      state             <= stateNext;
      txStartOUT        <= (stateNext == LOAD);
      frameDoneOUT      <= latchEnd;
      triggerDroppedOUT <= triggerDrop;
      pending           <= pendingNext;
      latchCount        <= (state == LATCH) ? latchCount + LW'(1) : '0;

      if (latchEnd) shift <= shiftNext;

      if (stateNext == FETCH) begin
        pixelIndex    <= '0;
        romAddressOUT <= (state == LATCH) ? shiftNext : shift;
      end

      if (stateNext == LOAD) begin
        txDataOUT <= loadData;
        if (state == WAIT_TX) pixelIndex <= pixelIndex + PW'(1);
      end

      // The next pixel is prefetched while the current one is sent.
      // The ROM word arrives on the second cycle in WAIT_TX.
      if (state == WAIT_ACK && txBusyIN) begin
        romAddressOUT <= addrInc;
        prefetchCount <= '0;
      end

      if (state == WAIT_TX) begin
        if (prefetchCount != 2'd2) prefetchCount <= prefetchCount + 2'd1;
        if (prefetchCount == 2'd1) holdData <= romDataIN;
      end
    end
  end

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Directed bench for ws2811_frame_sequencer.
//   Configuration: 3 pixels per frame, 5-deep pattern ROM with ROM[i] = i,
//   and an 8-cycle latch gap.
//   The transmitter model holds txBusyIN for busyLen cycles after each start.
//   A frame table drives the first four frames and so covers the shift wrap.
//   Hand-written sequences cover pending/drop, trigger on the last latch cycle,
//   reset in WAIT_TX, and the optional brightness scaling.

module tb_ws2811_frame_sequencer;

  localparam int unsigned DEPTH = 5;

  logic        clkIN = 1'b0;
  logic        nResetIN = 1'b0;
  logic        frameTriggerIN = 1'b0;
  logic        txBusyIN;
  logic [2:0]  romAddressOUT;
  logic [23:0] romDataIN = '0;
  logic [23:0] txDataOUT;
  logic        txStartOUT;
  logic        busyOUT;
  logic        frameDoneOUT;
  logic        triggerDroppedOUT;
`ifdef WS2811_BRIGHTNESS_EN
  logic [7:0]  brightnessIN = 8'd255;
`endif

  logic [23:0] rom [DEPTH];

  ws2811_frame_sequencer #(
    .UNITS_NUMBER(3),
    .PATTERN_PIXELS_NUMBER(DEPTH),
    .CLOCK_SPEED(1_000_000),
    .LATCH_US(8)
  ) dut (
    .clkIN(clkIN),
    .nResetIN(nResetIN),
    .frameTriggerIN(frameTriggerIN),
    .romAddressOUT(romAddressOUT),
    .romDataIN(romDataIN),
`ifdef WS2811_BRIGHTNESS_EN
    .brightnessIN(brightnessIN),
`endif
    .txStartOUT(txStartOUT),
    .txDataOUT(txDataOUT),
    .txBusyIN(txBusyIN),
    .busyOUT(busyOUT),
    .frameDoneOUT(frameDoneOUT),
    .triggerDroppedOUT(triggerDroppedOUT)
  );

  always #5 clkIN = ~clkIN;

  int cyc = 0;
  always @(posedge clkIN) cyc <= cyc + 1;

  // Synchronous ROM with a one-cycle read latency.
  always @(posedge clkIN)
    romDataIN <= (int'(romAddressOUT) < DEPTH) ? rom[int'(romAddressOUT)] : 24'hEEEEEE;

  // Transmitter model.
  int busyLen = 1;
  int busyLeft;
  always @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      txBusyIN  <= 1'b0;
      busyLeft  <= 0;
    end else if (txBusyIN) begin
      if (busyLeft <= 1) txBusyIN <= 1'b0;
      busyLeft <= busyLeft - 1;
    end else if (txStartOUT) begin
      txBusyIN <= 1'b1;
      busyLeft <= busyLen;
    end
  end

  // Event monitor, sampled on the falling edge.
  typedef struct {
    int          cyc;
    logic [23:0] data;
  } start_t;
  start_t startLog[$];
  int   doneCount = 0;
  int   doneCyc   = 0;
  int   dropCount = 0;
  int   fallCyc   = 0;
  logic prevBusy  = 1'b0;

  always @(negedge clkIN) begin
    if (txStartOUT) startLog.push_back('{cyc, txDataOUT});
    if (frameDoneOUT) begin
      doneCount++;
      doneCyc = cyc;
    end
    if (triggerDroppedOUT) dropCount++;
    if (prevBusy && !txBusyIN) fallCyc = cyc;
    prevBusy = txBusyIN;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(negedge clkIN);
    #1;
  endtask

  task automatic pulseTrigger(output int trigCyc);
    frameTriggerIN = 1'b1;
    trigCyc = cyc;
    tick();
    frameTriggerIN = 1'b0;
  endtask

  task automatic waitDone(input string name, input int target);
    int n;
    n = 0;
    while (doneCount < target && n < 300) begin
      tick();
      n++;
    end
    check({name, " frameDone reached"}, 32'(doneCount >= target), 32'd1);
  endtask

  task automatic checkFrame(input string name, input logic [23:0] e0, input logic [23:0] e1,
                            input logic [23:0] e2);
    logic [23:0] expv [3];
    logic [23:0] got;
    expv = '{e0, e1, e2};
    check({name, " start count"}, 32'(startLog.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < startLog.size()) ? startLog[i].data : 24'hxxxxxx;
      check($sformatf("%s pixel%0d data", name, i), 32'(got), 32'(expv[i]));
    end
  endtask

  task automatic checkAllZero(input string name);
    check({name, " romAddressOUT"},     32'(romAddressOUT),     32'd0);
    check({name, " txStartOUT"},        32'(txStartOUT),        32'd0);
    check({name, " txDataOUT"},         32'(txDataOUT),         32'd0);
    check({name, " busyOUT"},           32'(busyOUT),           32'd0);
    check({name, " frameDoneOUT"},      32'(frameDoneOUT),      32'd0);
    check({name, " triggerDroppedOUT"}, 32'(triggerDroppedOUT), 32'd0);
  endtask

  typedef struct {
    int          busyCycles;
    logic [2:0]  firstAddr;
    logic [23:0] d0;
    logic [23:0] d1;
    logic [23:0] d2;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int tc, tmp, d0, dr0, dcyc, n;

    for (int i = 0; i < DEPTH; i++) rom[i] = 24'(i);

    vecs[0] = '{1, 3'd0, 24'd0, 24'd1, 24'd2};
    vecs[1] = '{3, 3'd1, 24'd1, 24'd2, 24'd3};
    vecs[2] = '{1, 3'd2, 24'd2, 24'd3, 24'd4};
    vecs[3] = '{5, 3'd3, 24'd3, 24'd4, 24'd0};

    repeat (3) tick();
    checkAllZero("reset");
    nResetIN = 1'b1;
    repeat (2) tick();
    check("idle after reset busyOUT", 32'(busyOUT), 32'd0);

    // First four frames: latency, data order, latch gap and shift wrap.
    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("frame%0d", v);
      busyLen = vecs[v].busyCycles;
      startLog.delete();
      d0 = doneCount;
      pulseTrigger(tc);
      check({tag, " first address"}, 32'(romAddressOUT), 32'(vecs[v].firstAddr));
      check({tag, " busyOUT in frame"}, 32'(busyOUT), 32'd1);
      waitDone(tag, d0 + 1);
      checkFrame(tag, vecs[v].d0, vecs[v].d1, vecs[v].d2);
      if (startLog.size() > 0)
        check({tag, " start latency"}, 32'(startLog[0].cyc - tc), 32'd3);
      check({tag, " latch gap"}, 32'(doneCyc - fallCyc), 32'd9);
      repeat (3) tick();
      check({tag, " idle after frame"}, 32'(busyOUT), 32'd0);
      check({tag, " single frameDone"}, 32'(doneCount - d0), 32'd1);
    end

    // Three triggers in one frame: one becomes pending, one is dropped.
    busyLen = 2;
    startLog.delete();
    d0  = doneCount;
    dr0 = dropCount;
    pulseTrigger(tc);
    repeat (4) tick();
    pulseTrigger(tmp);
    check("pend no drop on 2nd", 32'(dropCount - dr0), 32'd0);
    repeat (3) tick();
    pulseTrigger(tmp);
    check("pend drop on 3rd", 32'(dropCount - dr0), 32'd1);
    waitDone("pend frameA", d0 + 1);
    dcyc = doneCyc;
    check("pend next frame busy at done", 32'(busyOUT), 32'd1);
    check("pend next address at done", 32'(romAddressOUT), 32'd0);
    checkFrame("pend frameA", 24'd4, 24'd0, 24'd1);
    startLog.delete();
    waitDone("pend frameB", d0 + 2);
    checkFrame("pend frameB", 24'd0, 24'd1, 24'd2);
    if (startLog.size() > 0)
      check("pend frameB start after done", 32'(startLog[0].cyc - dcyc), 32'd2);
    repeat (3) tick();
    check("pend idle afterwards", 32'(busyOUT), 32'd0);
    check("pend total drops", 32'(dropCount - dr0), 32'd1);

    // A trigger on the last latch cycle starts the next frame without a drop.
    busyLen = 1;
    startLog.delete();
    d0  = doneCount;
    dr0 = dropCount;
    pulseTrigger(tc);
    n = 0;
    while (!(startLog.size() >= 3 && fallCyc > startLog[startLog.size()-1].cyc) && n < 300) begin
      tick();
      n++;
    end
    check("edge last pixel finished", 32'(n < 300), 32'd1);
    repeat (8) tick();
    pulseTrigger(tmp);
    check("edge frameDone with trigger", 32'(frameDoneOUT), 32'd1);
    check("edge no drop", 32'(triggerDroppedOUT), 32'd0);
    check("edge restarted", 32'(busyOUT), 32'd1);
    check("edge next address", 32'(romAddressOUT), 32'd2);
    checkFrame("edge frameA", 24'd1, 24'd2, 24'd3);
    startLog.delete();
    waitDone("edge frameB", d0 + 2);
    checkFrame("edge frameB", 24'd2, 24'd3, 24'd4);
    check("edge drops", 32'(dropCount - dr0), 32'd0);
    repeat (3) tick();

    // Reset while the first pixel is being transmitted.
    busyLen = 6;
    startLog.delete();
    pulseTrigger(tc);
    n = 0;
    while (!txBusyIN && n < 50) begin
      tick();
      n++;
    end
    check("rst transmitter busy", 32'(txBusyIN), 32'd1);
    repeat (2) tick();
    check("rst txDataOUT before", 32'(txDataOUT), 32'd3);
    check("rst prefetch address", 32'(romAddressOUT), 32'd4);
    #2;
    nResetIN = 1'b0;
    #1;
    checkAllZero("rst async");
    tick();
    tick();
    nResetIN = 1'b1;
    tick();
    busyLen = 1;
    startLog.delete();
    d0 = doneCount;
    pulseTrigger(tc);
    check("rst restart address", 32'(romAddressOUT), 32'd0);
    waitDone("rst frame", d0 + 1);
    checkFrame("rst frame", 24'd0, 24'd1, 24'd2);
    repeat (3) tick();

`ifdef WS2811_BRIGHTNESS_EN
    rom[1] = 24'hFF8040;
    brightnessIN = 8'd127;
    startLog.delete();
    d0 = doneCount;
    pulseTrigger(tc);
    waitDone("bright127", d0 + 1);
    check("bright127 data", 32'((startLog.size() > 0) ? startLog[0].data : 24'hxxxxxx), 32'h7F4020);
    repeat (3) tick();
    rom[2] = 24'hFF8040;
    brightnessIN = 8'd255;
    startLog.delete();
    d0 = doneCount;
    pulseTrigger(tc);
    waitDone("bright255", d0 + 1);
    check("bright255 data", 32'((startLog.size() > 0) ? startLog[0].data : 24'hxxxxxx), 32'hFF8040);
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ws2811_frame_sequencer.md
WS2811_FRAME_SEQUENCER -- requirements
Module: ws2811_frame_sequencer

Interface
REQ-001 SHALL have parameter UNITS_NUMBER, default 100, giving the pixels sent per frame (legal range 1..4095).
REQ-002 SHALL have parameter PATTERN_PIXELS_NUMBER, default 128, giving the pattern ROM depth (legal range 2..4096, any value).
REQ-003 SHALL have parameter CLOCK_SPEED, default 50_000_000, giving the clkIN frequency in Hz.
REQ-004 SHALL have parameter LATCH_US, default 300, giving the minimum idle-line gap after a frame, in microseconds.
REQ-005 SHALL have port clkIN, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port nResetIN, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port frameTriggerIN, input, 1 bit: frame request, sampled each cycle while high.
REQ-008 SHALL have port romAddressOUT, output, $clog2(PATTERN_PIXELS_NUMBER) bits: registered ROM read address.
REQ-009 SHALL have port romDataIN, input, 24 bits: ROM data, valid exactly one cycle after the address (GRB order).
REQ-010 SHALL have port txStartOUT, output, 1 bit: one-cycle start pulse to the transmitter.
REQ-011 SHALL have port txDataOUT, output, 24 bits: pixel data, held stable from the start pulse until the transmitter asserts busy.
REQ-012 SHALL have port txBusyIN, input, 1 bit: transmitter busy; rises within 2 cycles of the start pulse and falls after the last bit.
REQ-013 SHALL have port busyOUT, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port frameDoneOUT, output, 1 bit: one-cycle pulse when the latch gap completes.
REQ-015 SHALL have port triggerDroppedOUT, output, 1 bit: one-cycle pulse when a trigger is discarded.

Function
REQ-016 SHALL implement the states IDLE, FETCH, WAIT_DATA, LOAD, WAIT_ACK, WAIT_TX and LATCH.
REQ-017 SHALL, in IDLE with frameTriggerIN=1 or pending=1, set pixelIndex=0, drive romAddressOUT=shift, clear pending, and go to FETCH.
REQ-018 SHALL advance unconditionally FETCH->WAIT_DATA->LOAD, capturing romDataIN into txDataOUT on entry to LOAD.
REQ-019 SHALL assert txStartOUT for exactly the LOAD cycle, so the start pulse comes 3 cycles after the trigger is sampled, then go to WAIT_ACK.
REQ-020 SHALL go from WAIT_ACK to WAIT_TX when txBusyIN=1, and SHALL never re-pulse start while in WAIT_ACK.
REQ-021 SHALL, on entry to WAIT_TX, present the address for pixelIndex+1, so the next pixel is prefetched into the holding register during transmission.
REQ-022 SHALL, in WAIT_TX when txBusyIN=0, go to LOAD with the prefetched data if pixelIndex+1<UNITS_NUMBER, otherwise go to LATCH.
REQ-023 SHALL compute the address as (pixelIndex+shift) mod PATTERN_PIXELS_NUMBER using compare-and-subtract, with correct wrap for a non-power-of-two depth.
REQ-024 SHALL hold LATCH for LATCH_CYCLES = CLOCK_SPEED/1_000_000*LATCH_US cycles with txStartOUT=0.
REQ-025 SHALL, at the end of LATCH, pulse frameDoneOUT and set shift = (shift+1) mod PATTERN_PIXELS_NUMBER.
REQ-026 SHALL, at the end of LATCH, go to FETCH if pending=1 (same cycle as frameDoneOUT), otherwise go to IDLE.
REQ-027 SHALL set pending when a trigger arrives while busyOUT=1.
REQ-028 SHALL pulse triggerDroppedOUT when a trigger arrives while pending is already set, and leave pending set.
REQ-029 SHALL, when a trigger coincides with the last LATCH cycle, treat it as pending, start the next frame, and not drop it.
REQ-030 SHALL leave the frame unaffected if txBusyIN stays high indefinitely (no timeout; documented hang).

Reset
REQ-031 SHALL, when nResetIN=0, immediately set state=IDLE, all outputs=0, and shift, pixelIndex, pending and the latch counter=0, including mid-frame.
REQ-032 SHALL start the first frame after reset release with shift=0, so address 0 is the first address.

Configuration
REQ-033 SHALL, with macro WS2811_BRIGHTNESS_EN defined, add input brightnessIN[7:0] and load each 8-bit channel into txDataOUT as (ch*(brightnessIN+1))>>8, with no added latency.
REQ-034 SHALL, without WS2811_BRIGHTNESS_EN, omit brightnessIN and load romDataIN into txDataOUT unchanged.

Verification
REQ-035 SHALL test a single trigger with UNITS_NUMBER=3, a 1-cycle busy model and ROM[i]=i: txStartOUT pulses 3 times carrying 0,1,2, and frameDoneOUT pulses once after the LATCH_CYCLES gap.
REQ-036 SHALL test shift wrap with PATTERN_PIXELS_NUMBER=5, UNITS_NUMBER=3 and 4 frames: frame 4 addresses are 3,4,0.
REQ-037 SHALL test 3 triggers during a frame: one frame is pending, triggerDroppedOUT pulses once, and the second frame starts in the same cycle as frameDoneOUT.
REQ-038 SHALL test nResetIN low during WAIT_TX: all outputs are 0 asynchronously, and the next trigger restarts at address 0.
REQ-039 SHALL test WS2811_BRIGHTNESS_EN with brightnessIN=127 and ROM=0xFF8040: txDataOUT=0x7F4020; with brightnessIN=255, txDataOUT=0xFF8040.
